video_frame_arb: RTL and testbench
==================================

VIDEO_FRAME_ARB -- requirements
Module: video_frame_arb

Interface
REQ-001 Parameter DATA_W, default 8, beat width of all stream data ports.
REQ-002 Parameter GAP_CYCLES, default 4, idle cycles inserted after every frame (legal 1..255).
REQ-003 Parameter TIMEOUT, default 64, max cycles without a granted-source beat before abort (used only with REQ-034).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 enable  input  1  when low, no new grant is issued; a frame in flight completes.
REQ-007 req0, req1  input  1 each  source n requests to send one frame.
REQ-008 start0, start1  output  1 each  one-cycle pulse telling source n to begin its frame.
REQ-009 s0_tdata/s1_tdata  input  DATA_W; s0_tvalid/s1_tvalid, s0_tlast/s1_tlast  input  1  source streams.
REQ-010 s0_tready, s1_tready  output  1  backpressure to sources.
REQ-011 m_tdata  output  DATA_W; m_tvalid, m_tlast  output  1; m_tready  input  1  merged output stream.
REQ-012 grant  output  2  one-hot owner of the output (00 when none).
REQ-013 frame_cnt  output  16  completed frames, wraps 0xFFFF->0.
REQ-014 err  output  1  sticky timeout flag (constant 0 without REQ-034).

Function
REQ-015 FSM states: IDLE, START, XFER, GAP (plus ABORT per REQ-034).
REQ-016 IDLE: if enable and any req, latch winner into grant, go START next cycle; else stay.
REQ-017 Arbitration round-robin at frame granularity: both requesting -> source not served last wins; single requester wins; after reset source 0 has priority.
REQ-018 START: exactly one cycle; start of granted source high only in this state; go XFER.
REQ-019 XFER: m_tdata/m_tvalid/m_tlast combinationally equal the granted source's tdata/tvalid/tlast; granted s_tready = m_tready; zero-cycle latency.
REQ-020 Ungranted s_tready SHALL be 0 in all states; m_tvalid SHALL be 0 outside XFER.
REQ-021 Frame ends on cycle with m_tvalid & m_tready & m_tlast: frame_cnt+1, last-served pointer updated, go GAP, grant cleared next cycle.
REQ-022 Beats with tvalid low (source stalls) SHALL be tolerated indefinitely unless REQ-034 compiled in.
REQ-023 GAP: hold GAP_CYCLES cycles (counter loaded on entry, exits when it reaches 1), then IDLE; requests ignored during GAP.
REQ-024 req changes during START/XFER/GAP SHALL not affect current grant.
REQ-025 enable deasserted mid-frame: frame completes normally, then FSM rests in IDLE.

Reset
REQ-026 On rst: state IDLE, grant 00, start0/start1 0, frame_cnt 0, err 0, GAP counter 0, pointer favouring source 0.
REQ-027 With grant 00 after reset, s0_tready, s1_tready, m_tvalid, m_tlast SHALL be 0 combinationally.
REQ-028 rst mid-frame SHALL abort immediately; no start pulse until a fresh IDLE->START transition.
REQ-029 Reset deassertion assumed synchronous to clk externally; block does not re-synchronise.

Configuration
REQ-030 Macro VIDEO_FRAME_ARB_TIMEOUT_EN selects the watchdog.
REQ-031 Without macro: no ABORT state, err tied 0, TIMEOUT unused.
REQ-032 With macro: cycle counter in XFER, cleared on each accepted beat, incremented otherwise.
REQ-033 Counter reaching TIMEOUT sets err (sticky until rst) and enters ABORT.
REQ-034 ABORT: one cycle, grant cleared, frame_cnt unchanged, pointer updated as if served, then GAP.

Verification
REQ-035 Single source: req0=1, source emits 160-beat frame (tlast on beat 160), m_tready=1 -> start0 one pulse, 160 beats out unchanged, frame_cnt=1, grant 01 then 00.
REQ-036 Round-robin: req0=req1=1 for 4 frames -> grant order 01,10,01,10; frame_cnt=4; GAP exactly 4 cycles between last beat and next start.
REQ-037 Backpressure: m_tready toggles 1/0 every cycle -> 160 beats delivered, no loss/duplication, ungranted tready always 0.
REQ-038 Reset mid-frame: rst at beat 50 -> next cycle grant 00, all outputs at reset values, frame_cnt=0; new req0 yields fresh start0.
REQ-039 With VIDEO_FRAME_ARB_TIMEOUT_EN, TIMEOUT=64: source stops valid after beat 10 -> err=1 at 64th idle cycle, grant 00, frame_cnt 0, other source served next.
REQ-040 enable=0 at beat 80 -> frame finishes, frame_cnt=1, no further start while req0=1 until enable=1.

Source files
------------

// File: rtl/video_frame_arb.sv
// rtl/video_frame_arb.sv - two-source round-robin frame arbiter onto one stream
// Optional XFER watchdog compiled in with VIDEO_FRAME_ARB_TIMEOUT_EN.
module video_frame_arb #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              req0,
  input  logic              req1,
  output logic              start0,
  output logic              start1,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic              s0_tvalid,
  input  logic              s0_tlast,
  output logic              s0_tready,
  input  logic [DATA_W-1:0] s1_tdata,
  input  logic              s1_tvalid,
  input  logic              s1_tlast,
  output logic              s1_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [1:0]        grant,
  output logic [15:0]       frame_cnt,
  output logic              err
);

  if (GAP_CYCLES < 1 || GAP_CYCLES > 255 || TIMEOUT < 1) begin : g_param_check
    $error("video_frame_arb: GAP_CYCLES must be 1..255 and TIMEOUT >= 1");
  end

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

`ifdef VIDEO_FRAME_ARB_TIMEOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_XFER, S_GAP, S_ABORT} state_t;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_XFER, S_GAP} state_t;
`endif

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;   // 1 = source 1 was served most recently
  logic [7:0]  gap_q, gap_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        beat_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= 2'b00;
      last_q      <= 1'b1;
      gap_q       <= 8'd0;
      frame_cnt_q <= 16'd0;
`ifdef VIDEO_FRAME_ARB_TIMEOUT_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      gap_q       <= gap_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef VIDEO_FRAME_ARB_TIMEOUT_EN
      wd_q        <= wd_d;
      err_q       <= err_d;
`endif
    end
  end

  // Datapath is a pure mux gated by XFER so the owner sees zero added latency.
  always_comb begin
    m_tdata   = '0;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    if (state_q == S_XFER) begin
      if (grant_q[0]) begin
        m_tdata   = s0_tdata;
        m_tvalid  = s0_tvalid;
        m_tlast   = s0_tlast;
        s0_tready = m_tready;
      end else if (grant_q[1]) begin
        m_tdata   = s1_tdata;
        m_tvalid  = s1_tvalid;
        m_tlast   = s1_tlast;
        s1_tready = m_tready;
      end
    end
  end

  assign beat_acc = m_tvalid & m_tready;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    gap_d       = gap_q;
    frame_cnt_d = frame_cnt_q;
`ifdef VIDEO_FRAME_ARB_TIMEOUT_EN
    wd_d        = wd_q;
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (enable && (req0 || req1)) begin
          grant_d = (req0 && (!req1 || last_q)) ? 2'b01 : 2'b10;
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_XFER;
`ifdef VIDEO_FRAME_ARB_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      S_XFER: begin
`ifdef VIDEO_FRAME_ARB_TIMEOUT_EN
        wd_d = beat_acc ? '0 : wd_q + 1'b1;
        if (!beat_acc && wd_q == WD_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          last_d  = grant_q[1];
          grant_d = 2'b00;
          state_d = S_ABORT;
        end
`endif
        if (beat_acc && m_tlast) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          last_d      = grant_q[1];
          grant_d     = 2'b00;
          gap_d       = GAP_LOAD;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q <= 8'd1) begin
          gap_d   = 8'd0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
`ifdef VIDEO_FRAME_ARB_TIMEOUT_EN
      S_ABORT: begin
        gap_d   = GAP_LOAD;
        state_d = S_GAP;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign start0    = (state_q == S_START) & grant_q[0];
  assign start1    = (state_q == S_START) & grant_q[1];
  assign grant     = grant_q;
  assign frame_cnt = frame_cnt_q;
`ifdef VIDEO_FRAME_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_video_frame_arb.sv
// tb/tb_video_frame_arb.sv - directed checks of video_frame_arb (default build)
module tb_video_frame_arb;

  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable, req0, req1;
  logic       start0, start1;
  logic [7:0] s0_tdata, s1_tdata, m_tdata;
  logic       s0_tvalid, s0_tlast, s0_tready;
  logic       s1_tvalid, s1_tlast, s1_tready;
  logic       m_tvalid, m_tlast, m_tready;
  logic [1:0] grant;
  logic [15:0] frame_cnt;
  logic       err;

  int checks = 0, failures = 0;
  int cycle = 0, n_st0 = 0, n_st1 = 0, bad_tready = 0;
  int start_cyc = 0, last_acc_cyc = 0;

  video_frame_arb #(.DATA_W(8), .GAP_CYCLES(GAP), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req0(req0), .req1(req1),
    .start0(start0), .start1(start1),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .grant(grant), .frame_cnt(frame_cnt), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (start0) n_st0++;
    if (start1) n_st1++;
    if ((s0_tready && !grant[0]) || (s1_tready && !grant[1]) || (m_tvalid && grant == 2'b00))
      bad_tready++;
  end

  typedef struct {
    logic en, r0, r1;
    logic [7:0] d0; logic v0, l0;
    logic [7:0] d1; logic v1, l1;
    logic rdy;
    logic [1:0] e_grant; logic e_st0, e_st1, e_mv, e_ml; logic [7:0] e_md;
    logic e_rd0, e_rd1; logic [15:0] e_fc;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic en, r0, r1, input logic [7:0] d0, input logic v0, l0,
                              input logic [7:0] d1, input logic v1, l1, input logic rdy,
                              input logic [1:0] g, input logic st0, st1, mv, ml,
                              input logic [7:0] md, input logic rd0, rd1, input logic [15:0] fc);
    vec_t v;
    v.en = en; v.r0 = r0; v.r1 = r1; v.d0 = d0; v.v0 = v0; v.l0 = l0;
    v.d1 = d1; v.v1 = v1; v.l1 = l1; v.rdy = rdy; v.e_grant = g; v.e_st0 = st0;
    v.e_st1 = st1; v.e_mv = mv; v.e_ml = ml; v.e_md = md; v.e_rd0 = rd0; v.e_rd1 = rd1;
    v.e_fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int src, input int b);
    return 8'((b * 7 + 3 + src * 64) & 255);
  endfunction

  task automatic set_src(input int src, input logic [7:0] d, input logic v, input logic l);
    if (src == 0) begin s0_tdata = d; s0_tvalid = v; s0_tlast = l; end
    else begin s1_tdata = d; s1_tvalid = v; s1_tlast = l; end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b1; req0 = 1'b0; req1 = 1'b0; m_tready = 1'b1;
    set_src(0, 8'h00, 1'b0, 1'b0);
    set_src(1, 8'h00, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Wait for src's start, then stream beats until stop_at (or whole frame) are accepted.
  task automatic run_frame(input int src, input int nbeats, input bit toggle,
                           input int stop_at, input int en_beat, input bit drop);
    int cyc, beat, lim, errs;
    bit seen;
    logic [7:0] exp_d;
    logic [1:0] oh;
    oh = (src == 0) ? 2'b01 : 2'b10;
    seen = 1'b0;
    for (cyc = 0; cyc < 50 && !seen; cyc++) begin
      @(negedge clk);
      if (start0 || start1) seen = 1'b1;
    end
    chk("start_seen", 32'(seen), 32'd1);
    if (!seen) return;
    chk("start_src", 32'((src == 0) ? start0 : start1), 32'd1);
    chk("start_grant", 32'(grant), 32'(oh));
    start_cyc = cycle;
    if (drop) begin
      if (src == 0) req0 = 1'b0; else req1 = 1'b0;
    end
    lim = (stop_at >= 0) ? stop_at : nbeats;
    beat = 0; errs = 0; cyc = 0;
    @(posedge clk); #1;
    m_tready = 1'b1;
    while (beat < lim && cyc < 2000) begin
      exp_d = pat(src, beat);
      set_src(src, exp_d, 1'b1, beat == nbeats - 1);
      if (beat == en_beat) enable = 1'b0;
      @(negedge clk);
      if (m_tvalid && m_tready) begin
        if (m_tdata !== exp_d || m_tlast !== (beat == nbeats - 1) || grant !== oh) errs++;
        last_acc_cyc = cycle;
        beat++;
      end
      @(posedge clk); #1;
      if (toggle) m_tready = ~m_tready;
      cyc++;
    end
    set_src(src, 8'h00, 1'b0, 1'b0);
    m_tready = 1'b1;
    chk("beats", 32'(beat), 32'(lim));
    chk("beat_errs", 32'(errs), 32'd0);
    if (beat == nbeats) chk("grant_cleared", 32'(grant), 32'd0);
  endtask

  initial begin
    int snap0, snap1, prev_last;

    tbl[0]  = mk(1,1,1, 8'h00,0,0, 8'h00,0,0, 1, 2'b00,0,0,0,0,8'h00,0,0, 16'd0);
    tbl[1]  = mk(1,1,1, 8'h00,0,0, 8'h00,0,0, 1, 2'b01,1,0,0,0,8'h00,0,0, 16'd0);
    tbl[2]  = mk(1,1,1, 8'h11,1,0, 8'h00,0,0, 1, 2'b01,0,0,1,0,8'h11,1,0, 16'd0);
    tbl[3]  = mk(1,1,1, 8'h22,0,0, 8'h00,0,0, 1, 2'b01,0,0,0,0,8'h00,1,0, 16'd0);
    tbl[4]  = mk(1,1,1, 8'h33,1,1, 8'h00,0,0, 0, 2'b01,0,0,1,1,8'h33,0,0, 16'd0);
    tbl[5]  = mk(1,1,1, 8'h33,1,1, 8'hbb,1,0, 1, 2'b01,0,0,1,1,8'h33,1,0, 16'd0);
    for (int i = 6; i <= 10; i++)
      tbl[i] = mk(1,1,1, 8'h44,1,1, 8'hbb,1,1, 1, 2'b00,0,0,0,0,8'h00,0,0, 16'd1);
    tbl[11] = mk(1,1,1, 8'h44,1,1, 8'hbb,1,1, 1, 2'b10,0,1,0,0,8'h00,0,0, 16'd1);
    tbl[12] = mk(1,1,1, 8'h44,1,1, 8'hb1,1,1, 1, 2'b10,0,0,1,1,8'hb1,0,1, 16'd1);
    for (int i = 13; i <= 18; i++)
      tbl[i] = mk(0,1,0, 8'h44,1,1, 8'hbb,1,1, 1, 2'b00,0,0,0,0,8'h00,0,0, 16'd2);

    enable = 1'b1; req0 = 1'b1; req1 = 1'b1; m_tready = 1'b1;
    set_src(0, 8'h5a, 1'b1, 1'b1);
    set_src(1, 8'ha5, 1'b1, 1'b1);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_start", 32'({start0, start1}), 32'd0);
    chk("rst_tready", 32'({s0_tready, s1_tready}), 32'd0);
    chk("rst_m", 32'({m_tvalid, m_tlast}), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    do_reset();
    for (int i = 0; i < 19; i++) begin
      enable = tbl[i].en; req0 = tbl[i].r0; req1 = tbl[i].r1; m_tready = tbl[i].rdy;
      set_src(0, tbl[i].d0, tbl[i].v0, tbl[i].l0);
      set_src(1, tbl[i].d1, tbl[i].v1, tbl[i].l1);
      @(negedge clk);
      chk($sformatf("row%0d_grant", i), 32'(grant), 32'(tbl[i].e_grant));
      chk($sformatf("row%0d_start", i), 32'({start0, start1}), 32'({tbl[i].e_st0, tbl[i].e_st1}));
      chk($sformatf("row%0d_mvl", i), 32'({m_tvalid, m_tlast}), 32'({tbl[i].e_mv, tbl[i].e_ml}));
      chk($sformatf("row%0d_tready", i), 32'({s0_tready, s1_tready}), 32'({tbl[i].e_rd0, tbl[i].e_rd1}));
      chk($sformatf("row%0d_fcnt", i), 32'(frame_cnt), 32'(tbl[i].e_fc));
      if (tbl[i].e_mv) chk($sformatf("row%0d_mdata", i), 32'(m_tdata), 32'(tbl[i].e_md));
      @(posedge clk); #1;
    end

    // single source 160-beat frame, then backpressured frame from source 1
    do_reset();
    snap0 = n_st0; snap1 = n_st1;
    req0 = 1'b1;
    run_frame(0, 160, 1'b0, -1, -1, 1'b1);
    chk("single_fcnt", 32'(frame_cnt), 32'd1);
    chk("single_start0", 32'(n_st0 - snap0), 32'd1);
    chk("single_start1", 32'(n_st1 - snap1), 32'd0);
    req1 = 1'b1;
    run_frame(1, 160, 1'b1, -1, -1, 1'b1);
    chk("bp_fcnt", 32'(frame_cnt), 32'd2);

    // round robin with both requesting; start follows last beat by GAP cycles plus IDLE
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      prev_last = last_acc_cyc;
      run_frame(k % 2, 5, 1'b0, -1, -1, 1'b0);
      if (k > 0) chk($sformatf("rr_gap%0d", k), 32'(start_cyc - prev_last), 32'(GAP + 2));
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("rr_fcnt", 32'(frame_cnt), 32'd4);

    // reset in the middle of a frame
    do_reset();
    req0 = 1'b1;
    run_frame(0, 160, 1'b0, 50, -1, 1'b1);
    rst = 1'b1;
    #1;
    chk("mrst_grant", 32'(grant), 32'd0);
    chk("mrst_out", 32'({start0, s0_tready, s1_tready, m_tvalid, m_tlast}), 32'd0);
    chk("mrst_fcnt", 32'(frame_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    snap0 = n_st0;
    req0 = 1'b1;
    run_frame(0, 3, 1'b0, -1, -1, 1'b1);
    chk("mrst_restart", 32'(n_st0 - snap0), 32'd1);
    chk("mrst_fcnt2", 32'(frame_cnt), 32'd1);

    // enable dropped mid-frame
    do_reset();
    req0 = 1'b1;
    run_frame(0, 160, 1'b0, -1, 80, 1'b0);
    chk("en_fcnt", 32'(frame_cnt), 32'd1);
    snap0 = n_st0;
    repeat (30) @(negedge clk);
    chk("en_nostart", 32'(n_st0 - snap0), 32'd0);
    chk("en_grant", 32'(grant), 32'd0);
    @(posedge clk); #1;
    enable = 1'b1;
    run_frame(0, 4, 1'b0, -1, -1, 1'b1);
    chk("en_fcnt2", 32'(frame_cnt), 32'd2);

    chk("ungranted_tready", 32'(bad_tready), 32'd0);
    chk("err_default", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
